// File: rtl/ram_arbiter_if.sv
// Requester-side bundle for ram_arbiter: two req/ack ports and shared read data.
// master = bus requesters, slave = arbiter.
interface ram_arbiter_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32
);
    logic                  req0;
    logic                  req1;
    logic                  wr0;
    logic                  wr1;
    logic [ADDR_WIDTH-1:0] addr0;
    logic [ADDR_WIDTH-1:0] addr1;
    logic [DATA_WIDTH-1:0] wdata0;
    logic [DATA_WIDTH-1:0] wdata1;
    logic                  ack0;
    logic                  ack1;
    logic [DATA_WIDTH-1:0] rdata;

    modport master (
        output req0, req1, wr0, wr1, addr0, addr1, wdata0, wdata1,
        input  ack0, ack1, rdata
    );

    modport slave (
        input  req0, req1, wr0, wr1, addr0, addr1, wdata0, wdata1,
        output ack0, ack1, rdata
    );
endinterface

// File: rtl/ram_arbiter.sv
// Two-port arbiter/sequencer for an active-low strobed single-port RAM.
// Define ARB_ROUND_ROBIN_EN for round-robin ties; otherwise port 0 has priority.
module ram_arbiter #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    ram_arbiter_if.slave          bus,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic                  ram_cs_n,
    output logic                  ram_we_n,
    output logic                  ram_oe_n,
    inout  wire  [DATA_WIDTH-1:0] ram_data
);
    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        RD0,
        RD1,
        DONE
    } state_t;

    state_t                state;
    logic                  gnt;
    logic                  drive;
    logic                  win;
    logic [DATA_WIDTH-1:0] wdata_q;

`ifdef ARB_ROUND_ROBIN_EN
    // 1 = port 1 was granted last, so port 0 wins the next tie
    logic last;

    always_comb begin
        win = bus.req1 & (~bus.req0 | ~last);
    end
`else
    always_comb begin
        win = bus.req1 & ~bus.req0;
    end
`endif

    assign ram_data = drive ? wdata_q : 'z;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            gnt       <= 1'b0;
            drive     <= 1'b0;
            wdata_q   <= '0;
            ram_addr  <= '0;
            ram_cs_n  <= 1'b1;
            ram_we_n  <= 1'b1;
            ram_oe_n  <= 1'b1;
            bus.ack0  <= 1'b0;
            bus.ack1  <= 1'b0;
            bus.rdata <= '0;
`ifdef ARB_ROUND_ROBIN_EN
            last      <= 1'b1;
`endif
        end else begin
            bus.ack0 <= 1'b0;
            bus.ack1 <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.req0 | bus.req1) begin
                        gnt      <= win;
                        ram_cs_n <= 1'b0;
                        ram_addr <= win ? bus.addr1 : bus.addr0;
                        wdata_q  <= win ? bus.wdata1 : bus.wdata0;
`ifdef ARB_ROUND_ROBIN_EN
                        last     <= win;
`endif
                        if (win ? bus.wr1 : bus.wr0) begin
                            ram_we_n <= 1'b0;
                            drive    <= 1'b1;
                            state    <= WRITE;
                        end else begin
                            ram_oe_n <= 1'b0;
                            state    <= RD0;
                        end
                    end
                end
                WRITE: begin
                    ram_cs_n <= 1'b1;
                    ram_we_n <= 1'b1;
                    drive    <= 1'b0;
                    bus.ack0 <= ~gnt;
                    bus.ack1 <= gnt;
                    state    <= DONE;
                end
                RD0: begin
                    state <= RD1;
                end
                RD1: begin
                    ram_cs_n  <= 1'b1;
                    ram_oe_n  <= 1'b1;
                    bus.rdata <= ram_data;
                    bus.ack0  <= ~gnt;
                    bus.ack1  <= gnt;
                    state     <= DONE;
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a registered-read RAM model on the bus.
// Build with or without ARB_ROUND_ROBIN_EN; tie expectations follow the macro.
module tb_ram_arbiter;
    logic        clk;
    logic        reset;
    logic [15:0] ram_addr;
    logic        ram_cs_n;
    logic        ram_we_n;
    logic        ram_oe_n;
    wire  [31:0] ram_data;

    int total;
    int bad;

    ram_arbiter_if bus ();

    ram_arbiter dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus),
        .ram_addr (ram_addr),
        .ram_cs_n (ram_cs_n),
        .ram_we_n (ram_we_n),
        .ram_oe_n (ram_oe_n),
        .ram_data (ram_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM model: write on the closing edge, read registered, bus driven the cycle after
    logic [31:0] mem [0:65535];
    logic [31:0] ram_q;
    logic        rd_d;
    logic        ram_drv;

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 32'h0;
        ram_q = 32'h0;
        rd_d  = 1'b0;
    end

    assign ram_drv  = !ram_cs_n && !ram_oe_n && rd_d;
    assign ram_data = ram_drv ? ram_q : 'z;

    always @(posedge clk) begin
        if (!ram_cs_n && !ram_we_n) mem[ram_addr] <= ram_data;
        if (!ram_cs_n && !ram_oe_n) ram_q <= mem[ram_addr];
        rd_d <= !ram_cs_n && !ram_oe_n;
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // Strobe legality and bus ownership every cycle
    always @(negedge clk) begin
        chk("strobe_legal",
            {63'h0, ({ram_cs_n, ram_we_n, ram_oe_n} inside {3'b111, 3'b001, 3'b010})},
            64'h1);
        if (ram_drv) chk("ram_drive_clean", {32'h0, ram_data}, {32'h0, ram_q});
        chk("single_ack", {63'h0, bus.ack0 & bus.ack1}, 64'h0);
    end

    task automatic set_port(input bit p, input bit w, input logic [15:0] a,
                            input logic [31:0] d);
        if (p) begin
            bus.wr1 = w; bus.addr1 = a; bus.wdata1 = d; bus.req1 = 1'b1;
        end else begin
            bus.wr0 = w; bus.addr0 = a; bus.wdata0 = d; bus.req0 = 1'b1;
        end
    endtask

    task automatic txn(input bit p, input bit w, input logic [15:0] a,
                       input logic [31:0] d, input logic [31:0] er);
        int          n;
        logic [2:0]  es;
        logic [1:0]  ea;
        n = w ? 2 : 3;
        @(negedge clk);
        set_port(p, w, a, d);
        for (int c = 1; c <= n; c++) begin
            @(negedge clk);
            es = (c == n) ? 3'b111 : (w ? 3'b001 : 3'b010);
            ea = (c == n) ? (p ? 2'b10 : 2'b01) : 2'b00;
            chk("strobe_ack", {59'h0, ram_cs_n, ram_we_n, ram_oe_n, bus.ack1, bus.ack0},
                {59'h0, es, ea});
            if (c < n) chk("ram_addr", {48'h0, ram_addr}, {48'h0, a});
            if (w && c == 1) chk("wdata_bus", {32'h0, ram_data}, {32'h0, d});
            if (!w && c == n) chk("rdata", {32'h0, bus.rdata}, {32'h0, er});
            if (c == n) begin
                if (p) bus.req1 = 1'b0;
                else   bus.req0 = 1'b0;
            end
        end
    endtask

    typedef struct {
        bit          p;
        bit          w;
        logic [15:0] a;
        logic [31:0] d;
        logic [31:0] er;
    } vec_t;

    vec_t vt [10];
    int   g [4];
    int   got;
    int   exp_g;
    int   c0;
    int   c1;

    initial begin
        vt[0] = '{0, 1, 16'h0003, 32'hDEADBEEF, 32'h0};
        vt[1] = '{0, 0, 16'h0003, 32'h0,        32'hDEADBEEF};
        vt[2] = '{1, 1, 16'h000A, 32'h12345678, 32'h0};
        vt[3] = '{1, 0, 16'h000A, 32'h0,        32'h12345678};
        vt[4] = '{0, 0, 16'h000A, 32'h0,        32'h12345678};
        vt[5] = '{1, 1, 16'h0000, 32'hFFFFFFFF, 32'h0};
        vt[6] = '{0, 0, 16'h0000, 32'h0,        32'hFFFFFFFF};
        vt[7] = '{0, 1, 16'hFFFF, 32'hA5A5A5A5, 32'h0};
        vt[8] = '{1, 0, 16'hFFFF, 32'h0,        32'hA5A5A5A5};
        vt[9] = '{1, 0, 16'h0003, 32'h0,        32'hDEADBEEF};

        total = 0;
        bad   = 0;
        bus.req0 = 0; bus.req1 = 0; bus.wr0 = 0; bus.wr1 = 0;
        bus.addr0 = 0; bus.addr1 = 0; bus.wdata0 = 0; bus.wdata1 = 0;

        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("reset_idle",
                {27'h0, ram_cs_n, ram_we_n, ram_oe_n, bus.ack1, bus.ack0, bus.rdata},
                {27'h0, 3'b111, 2'b00, 32'h0});
        end
        chk("reset_addr", {48'h0, ram_addr}, 64'h0);

        for (int i = 0; i < 10; i++)
            txn(vt[i].p, vt[i].w, vt[i].a, vt[i].d, vt[i].er);

        // Simultaneous requests held through several grants
        @(negedge clk);
        for (int i = 0; i < 4; i++) g[i] = 9;
        got = 0;
        set_port(0, 1, 16'h0005, 32'h11111111);
        set_port(1, 1, 16'h0006, 32'h22222222);
        for (int c = 0; c < 40 && got < 4; c++) begin
            @(negedge clk);
            if (bus.ack0) begin g[got] = 0; got++; end
            else if (bus.ack1) begin g[got] = 1; got++; end
            if (got == 4) begin bus.req0 = 0; bus.req1 = 0; end
        end
        bus.req0 = 0;
        bus.req1 = 0;
        for (int i = 0; i < 4; i++) begin
`ifdef ARB_ROUND_ROBIN_EN
            exp_g = i % 2;
`else
            exp_g = 0;
`endif
            chk("tie_grant", 64'(g[i]), 64'(exp_g));
        end

        txn(1, 1, 16'h0006, 32'h22222222, 32'h0);

        // Write then read back to back: bus turnaround
        @(negedge clk);
        c0 = 0;
        c1 = 0;
        set_port(0, 1, 16'h0007, 32'h77777777);
        set_port(1, 0, 16'h0006, 32'h0);
        for (int c = 1; c <= 20 && (c0 == 0 || c1 == 0); c++) begin
            @(negedge clk);
            if (bus.ack0) begin c0 = c; bus.req0 = 0; end
            if (bus.ack1) begin
                c1 = c;
                bus.req1 = 0;
                chk("b2b_rdata", {32'h0, bus.rdata}, {32'h0, 32'h22222222});
            end
        end
        bus.req0 = 0;
        bus.req1 = 0;
        chk("b2b_ack0_cycle", 64'(c0), 64'd2);
        chk("b2b_ack1_cycle", 64'(c1), 64'd6);
        txn(0, 0, 16'h0007, 32'h0, 32'h77777777);

        // Reset during RD0
        @(negedge clk);
        set_port(0, 0, 16'h0005, 32'h0);
        @(negedge clk);
        chk("rd0_strobe", {61'h0, ram_cs_n, ram_we_n, ram_oe_n}, {61'h0, 3'b010});
        reset = 1'b1;
        bus.req0 = 0;
        @(negedge clk);
        chk("rd0_reset",
            {27'h0, ram_cs_n, ram_we_n, ram_oe_n, bus.ack1, bus.ack0, bus.rdata},
            {27'h0, 3'b111, 2'b00, 32'h0});
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("rd0_no_ack", {62'h0, bus.ack1, bus.ack0}, 64'h0);
        end
        txn(0, 0, 16'h0005, 32'h0, 32'h11111111);

        // Reset during WRITE: data still lands in the RAM
        @(negedge clk);
        set_port(1, 1, 16'h0009, 32'hCAFEF00D);
        @(negedge clk);
        chk("wr_strobe", {61'h0, ram_cs_n, ram_we_n, ram_oe_n}, {61'h0, 3'b001});
        reset = 1'b1;
        bus.req1 = 0;
        @(negedge clk);
        chk("wr_reset",
            {59'h0, ram_cs_n, ram_we_n, ram_oe_n, bus.ack1, bus.ack0},
            {59'h0, 3'b111, 2'b00});
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("wr_no_ack", {62'h0, bus.ack1, bus.ack0}, 64'h0);
        end
        txn(0, 0, 16'h0009, 32'h0, 32'hCAFEF00D);

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
